led_blink_arbiter: RTL
======================

Name: led_blink_arbiter

Overview:
- Shares a single board LED among NUM_REQ status requesters.
- Each requester asks for a blink code of N flashes. The block grants requesters round-robin, times the flashes with an internal CLK_FREQ/TICK_HZ tick divider, then inserts an inter-code gap before the next grant.
- Sits between status sources (FSMs, error flags) and the led_pin pad on the board top level.

Parameters:
CLK_FREQ, 125000000, input clock frequency in Hz
TICK_HZ, 10, timing tick rate; DIV = CLK_FREQ/TICK_HZ (integer, must be >= 1)
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 4, width of each blink-count field
ON_TICKS, 2, ticks LED is on per flash
OFF_TICKS, 3, ticks LED is off between flashes of one code
GAP_TICKS, 10, ticks LED is off after a code, before the next grant

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  request per requester, level
req_count  in  NUM_REQ*CNT_W  blink count; requester i uses bits [i*CNT_W +: CNT_W]
gnt  out  NUM_REQ  one-hot grant, held for the whole service
done  out  1  one-cycle pulse at end of service
busy  out  1  high whenever state != IDLE
led_pin  out  1  LED drive, active high

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- All outputs are registered.
- Reset values:
  - gnt=0, done=0, busy=0, led_pin=0
  - state=IDLE, round-robin pointer ptr=0
  - divider counter=0, tick-phase counter=0, remaining-blinks=0
- Reset asserted mid-service restores all reset values at the next edge. The service is abandoned and no done pulse is issued.
- Tick divider:
  - Counts 0..DIV-1 while busy; tick is a pulse when count==DIV-1.
  - Cleared to 0 on each grant, so phase lengths are exact multiples of DIV cycles.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - At an edge where any req bit is high, select the first set bit searching from ptr upward with wrap.
  - At that edge: gnt <= onehot(sel), busy <= 1, latch remaining <= req_count[sel].
  - If count != 0: state <= ON and led_pin <= 1. If count == 0: state <= GAP and led_pin <= 0.
  - Latency: grant appears on the edge that samples req. No combinational path from req to gnt.
- ON: after ON_TICKS ticks, remaining decrements.
  - If the new value is 0: go to GAP with led_pin <= 0.
  - Otherwise: go to OFF with led_pin <= 0.
- OFF: after OFF_TICKS ticks, go to ON with led_pin <= 1.
- GAP: after GAP_TICKS ticks, at one edge:
  - gnt <= 0, busy <= 0, done <= 1 for one cycle
  - ptr <= sel+1 mod NUM_REQ
  - state <= IDLE
- Service length for count n >= 1 is DIV*(n*ON_TICKS + (n-1)*OFF_TICKS + GAP_TICKS) cycles. For n = 0 it is DIV*GAP_TICKS cycles.
- req and req_count are ignored while busy. The requester may drop req after gnt.
- A req still high after done is eligible again. Round-robin order guarantees every persistent requester is served within NUM_REQ services.
- The earliest new grant is the cycle after done (IDLE lasts at least 1 cycle).
- Phase and tick counters are sized to hold max(ON_TICKS, OFF_TICKS, GAP_TICKS) and DIV-1. No wrap-around occurs within a phase.

Optional Feature:
- Macro: BLINK_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - When abort is high at an edge in ON/OFF/GAP: led_pin <= 0, gnt <= 0, busy <= 0, done <= 1, ptr <= sel+1, state <= IDLE. No gap is inserted.
  - abort in IDLE is ignored. Reset has priority over abort.
- Not defined: the abort port is absent and a service always runs to completion.

Test Plan:
All scenarios use CLK_FREQ=8, TICK_HZ=2 (DIV=4), NUM_REQ=4, ON=2, OFF=3, GAP=10.
1. req=0001, count0=2 -> gnt=0001 on the sampling edge; led_pin high 8 cycles, low 12, high 8, low 40; done pulses once at cycle 68 after grant; busy low the next cycle.
2. req=0101 simultaneously, ptr=0, counts=1 -> requester 0 served first (48 cycles), then gnt=0100 one cycle after done; ptr=3 at the end.
3. req=0010, count1=0 -> led_pin never high; gnt=0010 for 40 cycles; single done pulse.
4. req held at 1111 continuously, counts=1 -> grant order 0001, 0010, 0100, 1000, 0001; exactly one done per grant.
5. Reset asserted during the second ON phase of scenario 1 -> next edge: led_pin=0, gnt=0, busy=0, done=0, ptr=0; no done pulse; a subsequent req=0001 restarts the full 68-cycle sequence.
6. (BLINK_ABORT_EN) abort pulsed 5 cycles into the OFF phase of scenario 1 -> next edge: led_pin=0, gnt=0, done=1, busy=0; ptr=1.

Source files
------------

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: shares one board LED among NUM_REQ status requesters.
// Requesters are granted round-robin. Each grant plays a blink code of
// req_count flashes, timed by a CLK_FREQ/TICK_HZ tick divider, and the code
// is followed by an inter-code gap. All outputs are registered.
// Optional build macro BLINK_ABORT_EN adds an 'abort' input that ends the
// current service early, with no gap.
module led_blink_arbiter #(
    parameter int CLK_FREQ  = 125000000,
    parameter int TICK_HZ   = 10,
    parameter int NUM_REQ   = 4,
    parameter int CNT_W     = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 3,
    parameter int GAP_TICKS = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
`ifdef BLINK_ABORT_EN
    input  logic                     abort,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     done,
    output logic                     busy,
    output logic                     led_pin
);

    localparam int DIV    = CLK_FREQ / TICK_HZ;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MAX_OF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_T  = (MAX_OF > GAP_TICKS) ? MAX_OF : GAP_TICKS;
    localparam int PH_W   = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;
    localparam int IDX_W  = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               done_q;
    logic               busy_q;
    logic               led_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   sel_q;
    logic [DIV_W-1:0]   div_q;
    logic [PH_W-1:0]    phase_q;
    logic [CNT_W-1:0]   rem_q;

    logic               sel_found_d;
    logic [IDX_W-1:0]   sel_idx_d;
    logic [CNT_W-1:0]   sel_cnt_d;
    logic               tick;

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign led_pin = led_q;

    // Pointer to the requester after the one just served, with wrap.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] s);
        if (s == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return s + 1'b1;
    endfunction

    assign tick = busy_q && (div_q == DIV_W'(DIV - 1));

    // Round-robin search: first set req bit from ptr upward, wrapping.
    always_comb begin
        int j;
        j           = 0;
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        sel_cnt_d   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (!sel_found_d && req[j]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = IDX_W'(j);
                sel_cnt_d   = req_count[j*CNT_W +: CNT_W];
            end
        end
    end

    // Service FSM with tick divider, phase counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
            ptr_q   <= '0;
            sel_q   <= '0;
            div_q   <= '0;
            phase_q <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                div_q <= tick ? '0 : div_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (sel_found_d) begin
                        gnt_q   <= NUM_REQ'(1) << sel_idx_d;
                        sel_q   <= sel_idx_d;
                        busy_q  <= 1'b1;
                        rem_q   <= sel_cnt_d;
                        div_q   <= '0;
                        phase_q <= '0;
                        if (sel_cnt_d != '0) begin
                            state_q <= ON;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= GAP;
                            led_q   <= 1'b0;
                        end
                    end
                end
                ON: begin
                    if (tick) begin
                        if (phase_q == PH_W'(ON_TICKS - 1)) begin
                            phase_q <= '0;
                            rem_q   <= rem_q - 1'b1;
                            led_q   <= 1'b0;
                            state_q <= (rem_q == CNT_W'(1)) ? GAP : OFF;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (phase_q == PH_W'(OFF_TICKS - 1)) begin
                            phase_q <= '0;
                            led_q   <= 1'b1;
                            state_q <= ON;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (phase_q == PH_W'(GAP_TICKS - 1)) begin
                            phase_q <= '0;
                            div_q   <= '0;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ptr_q   <= next_ptr(sel_q);
                            state_q <= IDLE;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef BLINK_ABORT_EN
            // Abort ends any active service immediately, skipping the gap.
            if (abort && (state_q != IDLE)) begin
                led_q   <= 1'b0;
                gnt_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                ptr_q   <= next_ptr(sel_q);
                phase_q <= '0;
                div_q   <= '0;
                rem_q   <= '0;
                state_q <= IDLE;
            end
`endif
        end
    end

endmodule
